// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx -- SD CMD-line transmitter.
//
// Takes a command index and argument from the command scheduler, passes the
// 40-bit payload {2'b01,index,arg} to an external CRC7 engine, and once the
// CRC comes back serialises the 48-bit frame {0,1,index,arg,crc7,1} MSB-first
// on the CMD pad. Each bit is held for one full bit_tick period.
//
// Optional feature: define SD_CMD_TX_NCC_EN to drive the pad high for 8 bit
// periods (Ncc) after the end bit before accepting the next command.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous, active-high
//   bit_tick   in   one-clk strobe per SD bit period
//   cmd_valid  in   command request, sampled only while cmd_ready=1
//   cmd_index  in   [5:0] command index
//   cmd_arg    in   [31:0] command argument
//   cmd_ready  out  high only while idle
//   crc_load   out  one-clk load pulse to the CRC7 engine
//   crc_data   out  [39:0] registered payload for the CRC7 engine
//   crc_ready  in   CRC7 result valid
//   crc_in     in   [6:0] CRC7 result
//   cmd_out    out  CMD pad data
//   cmd_oe     out  CMD pad output enable
//   done       out  one-clk pulse when a frame completes
//   crc_err    out  one-clk pulse when the CRC engine times out
module sd_cmd_tx #(
  parameter int CRC_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_tick,
  input  logic        cmd_valid,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_ready,
  output logic        crc_load,
  output logic [39:0] crc_data,
  input  logic        crc_ready,
  input  logic [6:0]  crc_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        done,
  output logic        crc_err
);

`ifdef SD_CMD_TX_NCC_EN
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_CRC, ALIGN, SEND, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_CRC, ALIGN, SEND} state_t;
`endif

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(CRC_TIMEOUT);
  localparam logic [5:0]      LAST_BIT = 6'd47;
`ifdef SD_CMD_TX_NCC_EN
  localparam logic [5:0]      LAST_GAP = 6'd7;
`endif

  state_t           state_reg, state_next;
  logic [39:0]      crc_data_reg, crc_data_next;
  logic [47:0]      shift_reg, shift_next;
  logic [5:0]       bit_cnt_reg, bit_cnt_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic             cmd_out_reg, cmd_out_next;
  logic             cmd_oe_reg, cmd_oe_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      crc_data_reg <= '0;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      cmd_out_reg  <= 1'b1;
      cmd_oe_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      crc_data_reg <= crc_data_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      cmd_out_reg  <= cmd_out_next;
      cmd_oe_reg   <= cmd_oe_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    crc_data_next = crc_data_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    cmd_out_next  = cmd_out_reg;
    cmd_oe_next   = cmd_oe_reg;
    done_next     = 1'b0;
    cmd_ready     = 1'b0;
    crc_load      = 1'b0;
    crc_err       = 1'b0;

    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          crc_data_next = {2'b01, cmd_index, cmd_arg};
          state_next    = LOAD;
        end
      end

      LOAD: begin
        crc_load    = 1'b1;
        // Counter holds the number of the current WAIT_CRC cycle (1-based),
        // so the abort fires in the CRC_TIMEOUT-th waiting cycle.
        to_cnt_next = TO_W'(1);
        state_next  = WAIT_CRC;
      end

      WAIT_CRC: begin
        if (crc_ready) begin
          // crc_data already carries the start and transmission bits, so the
          // full 48-bit frame is just payload, CRC and the end bit.
          shift_next  = {crc_data_reg, crc_in, 1'b1};
          to_cnt_next = '0;
          state_next  = ALIGN;
        end else if (to_cnt_reg == TO_LAST) begin
          crc_err     = 1'b1;
          to_cnt_next = '0;
          state_next  = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end

      ALIGN: begin
        // Start on a tick so the start bit lasts a whole bit period.
        if (bit_tick) begin
          cmd_oe_next  = 1'b1;
          cmd_out_next = shift_reg[47];
          bit_cnt_next = '0;
          state_next   = SEND;
        end
      end

      SEND: begin
        if (bit_tick) begin
          if (bit_cnt_reg == LAST_BIT) begin
            done_next    = 1'b1;
            cmd_out_next = 1'b1;
            bit_cnt_next = '0;
`ifdef SD_CMD_TX_NCC_EN
            state_next   = GAP;
`else
            cmd_oe_next  = 1'b0;
            state_next   = IDLE;
`endif
          end else begin
            shift_next   = {shift_reg[46:0], 1'b0};
            cmd_out_next = shift_reg[46];
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end
        end
      end

`ifdef SD_CMD_TX_NCC_EN
      GAP: begin
        // Pad stays driven high for the Ncc bit periods.
        if (bit_tick) begin
          if (bit_cnt_reg == LAST_GAP) begin
            cmd_oe_next  = 1'b0;
            bit_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end
        end
      end
`endif

      default: state_next = IDLE;
    endcase
  end

  assign crc_data = crc_data_reg;
  assign cmd_out  = cmd_out_reg;
  assign cmd_oe   = cmd_oe_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_sd_cmd_tx.sv
`timescale 1ns/1ps
module tb_sd_cmd_tx;

`ifdef SD_CMD_TX_NCC_EN
  localparam int GAP_TICKS = 8;
`else
  localparam int GAP_TICKS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_ready, crc_load;
  logic [39:0] crc_data;
  logic        crc_ready = 1'b0;
  logic [6:0]  crc_in = '0;
  logic        cmd_out, cmd_oe, done, crc_err;

  sd_cmd_tx #(.CRC_TIMEOUT(64), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .bit_tick(bit_tick),
    .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .crc_load(crc_load), .crc_data(crc_data),
    .crc_ready(crc_ready), .crc_in(crc_in),
    .cmd_out(cmd_out), .cmd_oe(cmd_oe), .done(done), .crc_err(crc_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC7, polynomial x^7 + x^3 + 1, MSB first, zero initial value.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // ---------------- reference model (per-transaction timeline) --------------
  // m_stage: 0 idle, 1 load cycle, 2 waiting for crc, 3 waiting for first tick,
  // 4 on the wire (m_ticks = ticks elapsed since the start bit went out).
  int          m_stage = 0;
  int          m_wait_n = 0;
  int          m_ticks = 0;
  logic [39:0] m_payload = '0;
  logic [47:0] m_frame = '0;
  bit          m_done = 0;
  bit          m_on = 0;

  always @(posedge clk) begin
    m_done = 0;
    if (reset) begin
      m_stage = 0; m_wait_n = 0; m_ticks = 0; m_payload = '0; m_on = 1;
    end else begin
      case (m_stage)
        0: if (cmd_valid) begin m_payload = {2'b01, cmd_index, cmd_arg}; m_stage = 1; end
        1: begin m_stage = 2; m_wait_n = 1; end
        2: if (crc_ready) begin m_frame = {m_payload, crc_in, 1'b1}; m_stage = 3; end
           else if (m_wait_n == 64) m_stage = 0;
           else m_wait_n++;
        3: if (bit_tick) begin m_stage = 4; m_ticks = 0; end
        4: if (bit_tick) begin
             m_ticks++;
             if (m_ticks == 48) m_done = 1;
             if (m_ticks == 48 + GAP_TICKS) m_stage = 0;
           end
        default: m_stage = 0;
      endcase
    end
  end

  // ---------------- compare, capture, tick and CRC engine stand-in ----------
  int          tick_phase = 0;
  int          eng_cnt = 0;
  int          eng_lat = 12;
  bit          eng_stub = 0;
  logic [6:0]  eng_val = '0;
  logic [47:0] cap = '0;
  int          cap_n = 0;
  logic [47:0] last_frame = '0;
  int          n_frames = 0;
  int          n_loads = 0;
  int          cyc = 0;
  int          load_cyc = 0;
  int          err_cyc = 0;
  bit          oe_seen = 0;
  logic        exp_out;

  always @(negedge clk) begin
    if (m_on) begin
      exp_out = 1'b1;
      if (m_stage == 4 && m_ticks < 48) exp_out = m_frame[47 - m_ticks];
      chk("cmd_ready", 64'(cmd_ready), 64'(m_stage == 0));
      chk("crc_load",  64'(crc_load),  64'(m_stage == 1));
      chk("crc_data",  64'(crc_data),  64'(m_payload));
      chk("crc_err",   64'(crc_err),   64'(m_stage == 2 && m_wait_n == 64 && !crc_ready));
      chk("cmd_oe",    64'(cmd_oe),    64'(m_stage == 4));
      chk("cmd_out",   64'(cmd_out),   64'(exp_out));
      chk("done",      64'(done),      64'(m_done));
    end
    // Capture each bit right after the tick that launched it; the leading 0
    // distinguishes a start bit from the idle-high gap.
    if (bit_tick && cmd_oe && cap_n < 48 && (cap_n > 0 || cmd_out == 1'b0)) begin
      cap = {cap[46:0], cmd_out};
      cap_n++;
    end
    if (done) begin last_frame = cap; n_frames++; cap_n = 0; end
    if (cmd_oe) oe_seen = 1;
    if (crc_load) begin n_loads++; load_cyc = cyc; end
    if (crc_err) err_cyc = cyc;
    cyc++;
    tick_phase = (tick_phase + 1) % 4;
    bit_tick = (tick_phase == 0);
    if (crc_load) begin
      crc_ready = 1'b0;
      eng_cnt   = eng_lat;
      eng_val   = crc7(crc_data);
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && !eng_stub) begin crc_ready = 1'b1; crc_in = eng_val; end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  int l0;

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input bit hold);
    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; cmd_valid = 1'b1;
    cap_n = 0; oe_seen = 0; l0 = n_loads;
    @(negedge clk);
    chk("load after accept", 64'(crc_load), 64'd1);
    chk("payload latched", 64'(crc_data), 64'({2'b01, idx, arg}));
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string name, output bit got_done, output bit got_err);
    int t;
    t = 0; got_done = 0; got_err = 0;
    while (t < 2000 && !got_done && !got_err) begin
      @(negedge clk);
      if (done) got_done = 1;
      else if (crc_err) got_err = 1;
      t++;
    end
    if (!got_done && !got_err) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no done/crc_err within 2000 cycles", name);
    end
  endtask

  bit gd, ge;
  int n, f0;
  logic [39:0] p2;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset cmd_oe",    64'(cmd_oe),    64'd0);
    chk("reset cmd_out",   64'(cmd_out),   64'd1);
    chk("reset crc_data",  64'(crc_data),  64'd0);
    chk("reset done",      64'(done),      64'd0);
    reset = 1'b0;

    // Model pins: known SD CRC7 values
    chk("crc7 CMD0", 64'(crc7(40'h4000000000)), 64'h4A);
    chk("crc7 CMD8", 64'(crc7(40'h48000001AA)), 64'h43);

    // CMD0, arg 0
    issue(6'd0, 32'h0, 0);
    chk("CMD0 crc_data", 64'(crc_data), 64'h4000000000);
    wait_end("CMD0", gd, ge);
    chk("CMD0 done", 64'(gd), 64'd1);
    chk("CMD0 oe at done", 64'(cmd_oe), 64'(GAP_TICKS != 0));
    n = 0;
    while (cmd_oe && n < 100) begin
      chk("gap cmd_out", 64'(cmd_out), 64'd1);
      n++;
      @(negedge clk);
    end
    chk("gap length clk", 64'(n), 64'(GAP_TICKS * 4));
    @(negedge clk);
    chk("CMD0 frame", 64'(last_frame), 64'h400000000095);
    chk("CMD0 single done", 64'(n_frames), 64'd1);
    $display("txn CMD0 arg=00000000 frame=%012h", last_frame);

    // CMD8 with cmd_valid held and index changed mid-frame
    issue(6'd8, 32'h000001AA, 1);
    chk("CMD8 crc_data", 64'(crc_data), 64'h48000001AA);
    cmd_index = 6'd5; cmd_arg = 32'hDEADBEEF;
    wait_end("CMD8", gd, ge);
    chk("CMD8 done", 64'(gd), 64'd1);
    chk("CMD8 one load", 64'(n_loads - l0), 64'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!crc_load && n < 300);
    chk("CMD8 frame", 64'(last_frame), 64'h48000001AA87);
    chk("held request accepted", 64'(crc_load), 64'd1);
    chk("accept after gap", 64'(n), 64'(GAP_TICKS * 4 + 1));
    $display("txn CMD8 arg=000001AA frame=%012h", last_frame);
    cmd_valid = 1'b0;
    wait_end("CMD5", gd, ge);
    @(negedge clk);
    p2 = {2'b01, 6'd5, 32'hDEADBEEF};
    chk("CMD5 frame", 64'(last_frame), 64'({p2, crc7(p2), 1'b1}));
    $display("txn CMD5 arg=DEADBEEF frame=%012h", last_frame);
    while (!cmd_ready) @(negedge clk);

    // CRC engine never answers
    eng_stub = 1;
    issue(6'd1, 32'h40FF8000, 0);
    wait_end("CMD1 timeout", gd, ge);
    chk("timeout crc_err", 64'(ge), 64'd1);
    @(negedge clk);
    chk("timeout latency", 64'(err_cyc - load_cyc), 64'd64);
    chk("timeout oe never", 64'(oe_seen), 64'd0);
    chk("timeout ready", 64'(cmd_ready), 64'd1);
    chk("timeout pulse", 64'(crc_err), 64'd0);
    $display("txn CMD1 arg=40FF8000 crc timeout after %0d cycles", err_cyc - load_cyc);
    eng_stub = 0;

    // Reset in the middle of CMD17
    issue(6'd17, 32'h00001000, 0);
    n = 0;
    while (cap_n < 21 && n < 1000) begin @(negedge clk); n++; end
    chk("CMD17 reached bit 20", 64'(cap_n >= 21), 64'd1);
    f0 = n_frames;
    reset = 1'b1;
    @(negedge clk);
    chk("midreset cmd_oe", 64'(cmd_oe), 64'd0);
    chk("midreset cmd_out", 64'(cmd_out), 64'd1);
    chk("midreset ready", 64'(cmd_ready), 64'd1);
    chk("midreset done", 64'(done), 64'd0);
    reset = 1'b0;
    $display("txn CMD17 arg=00001000 abandoned by reset");
    issue(6'd0, 32'h0, 0);
    wait_end("CMD0 after reset", gd, ge);
    @(negedge clk);
    chk("no done from CMD17", 64'(n_frames - f0), 64'd1);
    chk("CMD0 after reset frame", 64'(last_frame), 64'h400000000095);
    $display("txn CMD0 arg=00000000 frame=%012h", last_frame);

    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
